// File: rtl/mult_div_unit_pkg.sv
// Shared defines for the multiply/divide unit: mdCtrl encodings and default latencies.
// Used by both the multiply/divide controller and the pipeline hazard unit.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;
  localparam int unsigned CNT_W           = 4;

  // MULT, MULTU, DIV and DIVU occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_counter.sv
// Loadable down-counter that times a multi-cycle operation.
// busy is high from the load edge until the edge on which the count reaches zero.
module md_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  // done marks the edge on which the count will reach zero.
  assign done = busy & (cnt == W'(1));

  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Operands are latched at start; the result is computed combinationally and written at completion.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  mdCtrl,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        start,
  output logic        busy,
  output logic [31:0] result
);

  logic             accept;
  logic             done;
  logic [CNT_W-1:0] load_val;
  md_op_e           op_q;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      hi, lo;
  logic [31:0]      hi_nxt, lo_nxt;

  assign accept   = en & ~busy;
  assign start    = accept & is_long_op(mdCtrl);
  assign load_val = ((mdCtrl == MD_MULT) || (mdCtrl == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                                  : CNT_W'(DIV_CYCLES);

  md_counter #(.W(CNT_W)) u_md_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= MD_NOP;
      op_a <= '0;
      op_b <= '0;
    end else if (start) begin
      op_q <= md_op_e'(mdCtrl);
      op_a <= inA;
      op_b <= inB;
    end
  end

  // Products: size casts of signed operands sign-extend before the multiply.
  logic [63:0] prod_s, prod_u;
  assign prod_s = 64'($signed(op_a)) * 64'($signed(op_b));
  assign prod_u = 64'(op_a) * 64'(op_b);

  // Division on magnitudes, with signs restored afterwards; 0x80000000 / -1 wraps to 0x80000000.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quot, rem;
  assign div_signed = (op_q == MD_DIV);
  assign a_neg      = div_signed & op_a[31];
  assign b_neg      = div_signed & op_b[31];
  assign num        = a_neg ? (32'd0 - op_a) : op_a;
  assign den        = b_neg ? (32'd0 - op_b) : op_b;
  assign den_safe   = (den == '0) ? 32'd1 : den;
  assign q_mag      = num / den_safe;
  assign r_mag      = num % den_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (done) begin
      case (op_q)
        MD_MULT:  {hi_nxt, lo_nxt} = prod_s;
        MD_MULTU: {hi_nxt, lo_nxt} = prod_u;
        MD_DIV, MD_DIVU: begin
          // A zero divisor still burns the full latency but leaves HI/LO untouched.
          if (op_b != '0) begin
            hi_nxt = rem;
            lo_nxt = quot;
          end
        end
        default: ;
      endcase
    end else if (accept) begin
      case (mdCtrl)
        MD_MTHI: hi_nxt = inA;
        MD_MTLO: lo_nxt = inA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

  always_comb begin
    result = '0;
    case (mdCtrl)
      MD_MFHI: result = hi;
      MD_MFLO: result = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus randomized operations
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  mdCtrl;
  logic [31:0] inA, inB;
  logic        start, busy;
  logic [31:0] result;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mdCtrl (mdCtrl),
    .inA    (inA),
    .inB    (inB),
    .start  (start),
    .busy   (busy),
    .result (result)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rd_q[$];
  int          busy_q[$];
  int          busy_cnt = 0;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        pend_wr = 1'b0;
  logic [31:0] pend_hi = '0, pend_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: architectural result of a long op.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic wr, output logic [31:0] h, output logic [31:0] l);
    longint      sp, sq, sr;
    logic [63:0] up;
    wr = 1'b1; h = m_hi; l = m_lo;
    case (op)
      MD_MULT: begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        up = 64'(sp);
        h = up[63:32]; l = up[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
      end
      MD_DIV: begin
        if (b == 0) wr = 1'b0;
        else begin
          sq = longint'(signed'(a)) / longint'(signed'(b));
          sr = longint'(signed'(a)) % longint'(signed'(b));
          l = 32'(sq); h = 32'(sr);
        end
      end
      MD_DIVU: begin
        if (b == 0) wr = 1'b0;
        else begin
          l = a / b; h = a % b;
        end
      end
      default: wr = 1'b0;
    endcase
  endtask

  // Monitor: busy-pulse length and MFHI/MFLO reads against the queues.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        if (busy_q.size() == 0) check("busy_unexpected", 32'(busy_cnt), 32'd0);
        else check("busy_len", 32'(busy_cnt), 32'(busy_q.pop_front()));
        busy_cnt = 0;
      end
      if ((mdCtrl == MD_MFHI || mdCtrl == MD_MFLO) && rd_q.size() != 0)
        check(mdCtrl == MD_MFHI ? "mfhi" : "mflo", result, rd_q.pop_front());
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push_len);
    model(op, a, b, pend_wr, pend_hi, pend_lo);
    @(posedge clk); #1;
    en = 1'b1; mdCtrl = op; inA = a; inB = b;
    @(negedge clk);
    check("start", 32'(start), 32'd1);
    if (push_len) busy_q.push_back((op == MD_MULT || op == MD_MULTU) ? MC : DC);
    @(posedge clk); #1;
    en = 1'b0; mdCtrl = MD_NOP;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("busy_timeout", 32'd1, 32'd0);
    if (pend_wr) begin m_hi = pend_hi; m_lo = pend_lo; end
    pend_wr = 1'b0;
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    en = 1'b1; mdCtrl = op; inA = a;
    @(posedge clk); #1;
    en = 1'b0; mdCtrl = MD_NOP;
    if (op == MD_MTHI) m_hi = a; else m_lo = a;
  endtask

  task automatic read_hilo();
    @(posedge clk); #1;
    en = 1'b1; mdCtrl = MD_MFHI; rd_q.push_back(m_hi);
    @(posedge clk); #1;
    mdCtrl = MD_MFLO; rd_q.push_back(m_lo);
    @(posedge clk); #1;
    en = 1'b0; mdCtrl = MD_NOP;
  endtask

  task automatic long_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(op, a, b, 1'b1);
    wait_done();
    read_hilo();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; mdCtrl = MD_NOP; inA = '0; inB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    mdCtrl = MD_MFHI; #1 check("reset_hi", result, 32'd0);
    mdCtrl = MD_MFLO; #1 check("reset_lo", result, 32'd0);
    mdCtrl = MD_NOP;

    long_op(MD_MULT,  32'hFFFF_FFFF, 32'd2);
    long_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    long_op(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    long_op(MD_DIVU,  32'd7,         32'd0);
    long_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    // MTLO and a second MULT while busy are ignored; reads during busy see old HI/LO.
    start_op(MD_MULT, 32'd3, 32'd4, 1'b1);
    en = 1'b1; mdCtrl = MD_MULT; inA = 32'd9; inB = 32'd9;
    @(negedge clk);
    check("start_while_busy", 32'(start), 32'd0);
    @(posedge clk); #1;
    mdCtrl = MD_MTLO; inA = 32'h1234;
    read_hilo();
    wait_done();
    read_hilo();
    mt_op(MD_MTLO, 32'h1234);
    read_hilo();
    mt_op(MD_MTHI, 32'hCAFE_F00D);
    read_hilo();

    // en low with a MULT code must not start anything.
    @(posedge clk); #1;
    en = 1'b0; mdCtrl = MD_MULT; inA = 32'd5; inB = 32'd6;
    @(negedge clk);
    check("start_en_low", 32'(start), 32'd0);
    @(negedge clk);
    check("busy_en_low", 32'(busy), 32'd0);
    mdCtrl = MD_NOP;
    read_hilo();

    // Reset in the third busy cycle of a DIV discards it.
    start_op(MD_DIV, 32'd1000, 32'd7, 1'b0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    #1 check("reset_mid_busy", 32'(busy), 32'd0);
    mdCtrl = MD_MFHI; #1 check("reset_mid_hi", result, 32'd0);
    mdCtrl = MD_MFLO; #1 check("reset_mid_lo", result, 32'd0);
    mdCtrl = MD_NOP;
    pend_wr = 1'b0; m_hi = '0; m_lo = '0;
    @(posedge clk); @(negedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    read_hilo();

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (op == MD_MTHI || op == MD_MTLO) begin
        mt_op(op, a);
        read_hilo();
      end else begin
        long_op(op, a, b);
      end
    end

    repeat (3) @(posedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("busy_q_drained", 32'(busy_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU (legal range 1-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (legal range 1-15).
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  EX-stage instruction valid; low on stall or flush.
REQ-006 SHALL have port mdCtrl  input  4  operation: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
REQ-007 SHALL have port inA  input  32  rs operand.
REQ-008 SHALL have port inB  input  32  rt operand.
REQ-009 SHALL have port start  output  1  combinational: en & (mdCtrl in MULT..DIVU) & ~busy.
REQ-010 SHALL have port busy  output  1  registered: operation in progress.
REQ-011 SHALL have port result  output  32  combinational: HI when mdCtrl=MFHI, LO when mdCtrl=MFLO, else 0.

Function
REQ-012 SHALL accept an operation only on a rising edge where en=1 and busy=0; ops presented while busy=1 are ignored (no state change).
REQ-013 SHALL, on accepting MULT/MULTU/DIV/DIVU, latch inA/inB and mdCtrl, load the cycle counter with MULT_CYCLES or DIV_CYCLES, and set busy=1 from the same edge.
REQ-014 SHALL decrement the counter on each subsequent edge; on the edge where it reaches 0, write HI/LO and clear busy, so busy is high for exactly N cycles and new HI/LO is visible on the cycle busy first reads 0.
REQ-015 SHALL keep HI/LO at their previous values for the whole busy period (MFHI/MFLO during busy return old values; the hazard unit stalls them on start|busy).
REQ-016 SHALL compute MULT as the signed 32x32->64 product and MULTU as the unsigned product, with HI=product[63:32] and LO=product[31:0].
REQ-017 SHALL compute DIV as signed truncating division (LO=quotient, HI=remainder with sign of dividend) and DIVU as unsigned division.
REQ-018 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-019 SHALL, for divisor 0 (DIV or DIVU), still run DIV_CYCLES of busy and then leave HI and LO unchanged.
REQ-020 SHALL, on accepted MTHI/MTLO, write inA into HI/LO at that edge with no busy cycles.
REQ-021 SHALL treat MFHI, MFLO, NOP and codes 9-15 as no state change.
REQ-022 SHALL make start=0 whenever busy=1, so a back-to-back MULT is accepted on the edge after busy falls.

Reset
REQ-023 SHALL, while reset=1, asynchronously force HI=0, LO=0, busy=0 and counter=0, discarding any operation in progress.
REQ-024 SHALL ignore en on the first edge after reset release only if reset is still high at that edge; otherwise operation resumes normally.

Structure
REQ-025 SHALL take the mdCtrl encodings and the MULT_CYCLES/DIV_CYCLES defaults from a shared defines package used by the controller and the hazard unit.
REQ-026 SHALL compute the result combinationally from the latched operands, registered only at completion, with no iterative divider.
REQ-027 SHALL keep a single sub-module md_counter, a loadable down-counter that produces busy.

Verification
REQ-028 SHALL check: MULT inA=0xFFFFFFFF inB=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-029 SHALL check: MULTU inA=0xFFFFFFFF inB=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 SHALL check: DIV inA=-7 inB=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged.
REQ-031 SHALL check: MTLO 0x1234 issued while busy -> ignored; after busy falls, MTLO 0x1234 -> MFLO result=0x00001234 on the next cycle.
REQ-032 SHALL check: reset pulsed at busy cycle 3 of a DIV -> busy=0, HI=LO=0 immediately, and no late write-back occurs.
REQ-033 SHALL check: en=0 with mdCtrl=MULT -> start=0 and no busy; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
